// File: rtl/prbs_pkg.sv
// Shared PRBS definitions used by both the on-chip generators and the checker,
// so both ends agree on a single polynomial.
package prbs_pkg;

  typedef enum logic [1:0] {StHunt, StVerify, StLocked} prbs_state_t;

  localparam int unsigned PRBS13_WIDTH = 13;
  localparam logic [12:0] PRBS13_TAPS  = 13'h100D;

  // Widest LFSR the shared feedback helper supports.
  localparam int unsigned PRBS_MAX_W = 32;

  // Feedback bit: XOR of the tapped state bits; callers zero-extend narrower LFSRs.
  function automatic logic prbs_next(input logic [PRBS_MAX_W-1:0] state,
                                     input logic [PRBS_MAX_W-1:0] taps);
    return ^(state & taps);
  endfunction

endpackage

// File: rtl/prbs_err_window.sv
// Loss-of-lock detector: counts valid bits in a fixed window and the errors seen in it.
module prbs_err_window #(
  parameter int unsigned WINDOW      = 128,
  parameter int unsigned LOSS_THRESH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample,
  input  logic bit_err,
  output logic loss
);

  localparam int unsigned CW = $clog2(WINDOW) + 1;

  logic [CW-1:0] win_bits_q, win_bits_d;
  logic [CW-1:0] win_err_q, win_err_d;

  // Combinational so the caller can drop lock on the edge sampling the threshold error.
  assign loss = sample && bit_err && ((win_err_q + CW'(1)) >= CW'(LOSS_THRESH));

  always_comb begin
    win_bits_d = win_bits_q;
    win_err_d  = win_err_q;
    if (sample) begin
      if (loss || (win_bits_q == CW'(WINDOW - 1))) begin
        win_bits_d = '0;
        win_err_d  = '0;
      end else begin
        win_bits_d = win_bits_q + CW'(1);
        if (bit_err) win_err_d = win_err_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_bits_q <= '0;
      win_err_q  <= '0;
    end else begin
      win_bits_q <= win_bits_d;
      win_err_q  <= win_err_d;
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker: hunts, verifies, then predicts each bit and
// counts errors while locked.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned       WIDTH       = PRBS13_WIDTH,
  parameter logic [WIDTH-1:0]  TAPS        = PRBS13_TAPS,
  parameter int unsigned       LOCK_COUNT  = 16,
  parameter int unsigned       WINDOW      = 128,
  parameter int unsigned       LOSS_THRESH = 8,
  parameter int unsigned       CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned FILL_W = $clog2(WIDTH) + 1;
  localparam int unsigned RUN_W  = $clog2(LOCK_COUNT) + 1;

  prbs_state_t      state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
  logic [RUN_W-1:0] run_q, run_d, run_inc;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pred;
  logic             bit_err;
  logic             win_sample;
  logic             loss;

  assign pred       = prbs_next(PRBS_MAX_W'(sreg_q), PRBS_MAX_W'(TAPS));
  assign fill_inc   = fill_q + FILL_W'(1);
  assign run_inc    = run_q + RUN_W'(1);
  assign win_sample = din_valid && (state_q == StLocked);
  assign bit_err    = win_sample && (din != pred);

  prbs_err_window #(
    .WINDOW     (WINDOW),
    .LOSS_THRESH(LOSS_THRESH)
  ) u_err_window (
    .clk    (clk),
    .rst_n  (rst_n),
    .sample (win_sample),
    .bit_err(bit_err),
    .loss   (loss)
  );

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    fill_d  = fill_q;
    run_d   = run_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    if (din_valid) begin
      unique case (state_q)
        StHunt: begin
          sreg_d = {sreg_q[WIDTH-2:0], din};
          fill_d = fill_inc;
          if (fill_inc == FILL_W'(WIDTH)) begin
            fill_d = '0;
            // An all-zero register is the LFSR lockup state: keep hunting.
            if (sreg_d != '0) state_d = StVerify;
          end
        end
        StVerify: begin
          if (din == pred) begin
            sreg_d = {sreg_q[WIDTH-2:0], pred};
            run_d  = run_inc;
            if (run_inc == RUN_W'(LOCK_COUNT)) state_d = StLocked;
          end else begin
            state_d = StHunt;
            fill_d  = '0;
            run_d   = '0;
          end
        end
        StLocked: begin
          // Shift the prediction so a channel error cannot corrupt later predictions.
          sreg_d = {sreg_q[WIDTH-2:0], pred};
          if (bit_err) begin
            err_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          end
          if (loss) begin
            state_d = StHunt;
            fill_d  = '0;
            run_d   = '0;
          end
        end
        default: state_d = StHunt;
      endcase
    end
    if (clr_cnt) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StHunt;
      sreg_q  <= '0;
      fill_q  <= '0;
      run_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      fill_q  <= fill_d;
      run_q   <= run_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign locked    = (state_q == StLocked);
  assign err       = err_q;
  assign err_count = cnt_q;

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial PRBS receiver and checker: the receive end of the on-chip LFSR generators. Accepts one bit per valid cycle and self-synchronises a local LFSR to the incoming stream. Once locked, it predicts each bit, flags mismatches and keeps a saturating error count. Used on the icestick to validate generator output looped back through pins or logic, and to measure bit-error rates.

## Interface
- `WIDTH`, 13: LFSR length in bits.
- `TAPS`, 13'h100D: feedback mask. New bit = XOR of `state & TAPS` (bits 12, 3, 2, 0). Shift is left; new bit enters at LSB.
- `LOCK_COUNT`, 16: consecutive correct predictions required to declare lock.
- `WINDOW`, 128: valid-bit window length for loss-of-lock evaluation.
- `LOSS_THRESH`, 8: errors within one window that force loss of lock.
- `CNT_W`, 32: error counter width.
- `clk`  in  1: single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `din`  in  1: received bit.
- `din_valid`  in  1: `din` is sampled only when high.
- `clr_cnt`  in  1: synchronous clear of `err_count`.
- `locked`  out  1: checker is synchronised.
- `err`  out  1: one-cycle pulse, the bit just checked was wrong.
- `err_count`  out  CNT_W: saturating count of errors while locked.

## Operation
- State machine: HUNT, VERIFY, LOCKED. Reset enters HUNT.
- **HUNT**
  - Each valid bit shifts into `state` (`{state[WIDTH-2:0], din}`) and increments `fill`.
  - When `fill` reaches WIDTH, go to VERIFY, unless `state` is all zeros. The all-zero state is the lockup state, so `fill` restarts at 0 and the checker stays in HUNT.
- **VERIFY**
  - `pred` = XOR of `state & TAPS`.
  - Each valid bit is compared to `pred`.
  - Match: shift in `pred` and increment `run`. When `run` reaches LOCK_COUNT, go to LOCKED.
  - Mismatch: go to HUNT with `fill` = 0 and `run` = 0.
  - `err` and `err_count` are never affected in VERIFY.
- **LOCKED**
  - `locked` = 1. Each valid bit is compared to `pred`.
  - The checker always shifts in `pred`, never `din`, so a single channel error does not propagate.
  - Mismatch: pulse `err` and increment `err_count`, saturating at all-ones. Also increment `win_err`.
  - `win_bits` counts valid bits from 0 to WINDOW-1. At wrap, `win_err` clears.
  - If `win_err` reaches LOSS_THRESH within a window, go to HUNT. This clears `locked`, `fill`, `run` and both window counters. `err_count` is retained.
- `din_valid` low: no state, counter or register change, and `err` is 0.
- `clr_cnt` together with an error in the same cycle: the clear wins (`err_count` = 0), but `err` still pulses.
- Reset mid-operation: all registers return to reset values immediately (asynchronous), regardless of state.
- Widths: `fill` and `run` use `$clog2` of their limit plus 1; `win_bits` and `win_err` use `$clog2(WINDOW)` plus 1. No truncation warnings allowed.

## Timing
- Reset values: `locked` = 0, `err` = 0, `err_count` = 0, state = HUNT, all internal counters = 0, `state` register = 0.
- All outputs are registered. `err` is high in the cycle after the clock edge that sampled the errored bit.
- Lock latency from HUNT with a clean stream: WIDTH + LOCK_COUNT valid bits (29 by default). `locked` rises on the edge that samples the last of these bits.
- Loss of lock: `locked` falls on the edge that samples the LOSS_THRESH-th error in a window. `err` also pulses for that bit.
- No combinational path from inputs to outputs.

## Structure
- Shared package `prbs_pkg` holds:
  - state enum `prbs_state_t` (HUNT, VERIFY, LOCKED);
  - default constants `PRBS13_TAPS` and `PRBS13_WIDTH`;
  - the function `prbs_next(state, taps)` returning the feedback bit.
- The generator also uses `prbs_pkg`, so both ends share one polynomial definition.
- One sub-module, `prbs_err_window`: the window bit counter, window error counter and loss-of-lock flag.

## Test plan
- **Clean lock:** reference generator seeded 13'h000F streams continuously with `din_valid` = 1 -> `locked` rises after exactly 29 valid bits. `err` stays 0 for 10,000 further bits and `err_count` stays 0.
- **Gapped valid:** same stream with `din_valid` toggling 1-0-1-0 -> lock after 29 valid bits (58 cycles). No `err` pulses.
- **Single error:** after lock, invert the bit at index 500 -> one `err` pulse, `err_count` = 1. `locked` stays 1, with no further errors for 1,000 bits (no propagation).
- **Loss of lock:** after lock, invert 8 bits within a 128-bit window -> 8 `err` pulses, `locked` falls on the 8th, `err_count` = 8. The checker relocks after 29 further clean bits.
- **Lockup and false lock:** feed 13 zeros -> checker stays in HUNT. Feed a wrong-polynomial stream -> no lock within 1,000 bits. In both cases `err_count` stays 0.
- **Clear, saturation and reset:**
  - `clr_cnt` in the same cycle as an error -> `err_count` = 0 and `err` = 1.
  - With `CNT_W` = 4 and 20 errors -> `err_count` holds 15.
  - `rst_n` low while LOCKED -> `locked` and `err_count` go to 0 asynchronously.
